calc2_port_issuer: RTL

Request issuer and response tracker for one calc2 request port. It accepts whole operations (command plus two operands) over a valid/ready interface and serialises each onto the calc2 two-cycle request protocol. It allocates 2-bit tags, matches calc2 responses back to tags, and returns results to the requester strictly in issue order. One instance sits directly upstream of each `reqN_*` / `out_*N` port group of `calc2_top`.

---
 rtl/calc2_pkg.sv | 23 ++
 rtl/calc2_port_issuer_if.sv | 37 +++
 rtl/calc2_tag_table.sv | 105 ++++++++++
 rtl/calc2_port_issuer.sv | 109 ++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 request-port issuer.
package calc2_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_t;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_ERR     = 2'd2,
        RESP_TIMEOUT = 2'd3
    } resp_t;

    typedef logic [1:0] tag_t;

    localparam int unsigned CALC2_NUM_TAGS = 4;

endpackage

// File: rtl/calc2_port_issuer_if.sv
// Requester-side and calc2-side signal bundle for one calc2_port_issuer instance.
interface calc2_port_issuer_if;

    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_cmd;
    logic [31:0]         in_op1;
    logic [31:0]         in_op2;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_resp;
    logic [31:0]         out_data;
    calc2_pkg::tag_t     out_tag;
    logic [3:0]          req_cmd_out;
    logic [31:0]         req_data_out;
    calc2_pkg::tag_t     req_tag_out;
    logic [1:0]          dut_resp_in;
    logic [31:0]         dut_data_in;
    calc2_pkg::tag_t     dut_tag_in;
    logic [2:0]          outstanding;
    logic                err_spurious;

    modport slave (
        input  in_valid, in_cmd, in_op1, in_op2, out_ready,
        input  dut_resp_in, dut_data_in, dut_tag_in,
        output in_ready, out_valid, out_resp, out_data, out_tag,
        output req_cmd_out, req_data_out, req_tag_out, outstanding, err_spurious
    );

    modport master (
        output in_valid, in_cmd, in_op1, in_op2, out_ready,
        output dut_resp_in, dut_data_in, dut_tag_in,
        input  in_ready, out_valid, out_resp, out_data, out_tag,
        input  req_cmd_out, req_data_out, req_tag_out, outstanding, err_spurious
    );

endinterface

// File: rtl/calc2_tag_table.sv
// Four-entry in-order scoreboard: tag allocation, response capture, head retirement.
// Optional per-entry response timeout is enabled by CALC2_ISSUE_TIMEOUT_EN.
module calc2_tag_table
    import calc2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        i_alloc,
    input  logic        i_retire,
    input  logic [1:0]  i_dut_resp,
    input  logic [31:0] i_dut_data,
    input  tag_t        i_dut_tag,
    output tag_t        o_tail,
    output logic        o_head_done,
    output logic [1:0]  o_head_resp,
    output logic [31:0] o_head_data,
    output tag_t        o_head_tag,
    output logic [2:0]  o_outstanding,
    output logic        o_err_spurious
);

    tag_t        r_head;
    tag_t        r_tail;
    logic [2:0]  r_outstanding;
    logic [CALC2_NUM_TAGS-1:0] r_issued;
    logic [CALC2_NUM_TAGS-1:0] r_done;
    logic [1:0]  r_resp [CALC2_NUM_TAGS];
    logic [31:0] r_data [CALC2_NUM_TAGS];
    logic        r_err;
`ifdef CALC2_ISSUE_TIMEOUT_EN
    logic [TO_W-1:0] r_cnt [CALC2_NUM_TAGS];
`endif

    logic w_resp_any;
    logic w_resp_hit;

    assign w_resp_any = (i_dut_resp != RESP_NONE);
    assign w_resp_hit = w_resp_any & r_issued[i_dut_tag] & ~r_done[i_dut_tag];

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_outstanding <= '0;
            r_issued      <= '0;
            r_done        <= '0;
            r_err         <= 1'b0;
            for (int i = 0; i < CALC2_NUM_TAGS; i++) begin
                r_resp[i] <= '0;
                r_data[i] <= '0;
`ifdef CALC2_ISSUE_TIMEOUT_EN
                r_cnt[i]  <= '0;
`endif
            end
        end else begin
`ifdef CALC2_ISSUE_TIMEOUT_EN
            // A same-cycle response is written below and overrides the timeout.
            for (int i = 0; i < CALC2_NUM_TAGS; i++) begin
                if (r_issued[i] && !r_done[i]) begin
                    r_cnt[i] <= r_cnt[i] + TO_W'(1);
                    if (r_cnt[i] + TO_W'(1) == TO_W'(TIMEOUT)) begin
                        r_done[i] <= 1'b1;
                        r_resp[i] <= RESP_TIMEOUT;
                        r_data[i] <= '0;
                    end
                end
            end
`endif
            if (w_resp_hit) begin
                r_done[i_dut_tag] <= 1'b1;
                r_resp[i_dut_tag] <= i_dut_resp;
                r_data[i_dut_tag] <= i_dut_data;
            end else if (w_resp_any) begin
                r_err <= 1'b1;
            end
            if (i_retire) begin
                r_issued[r_head] <= 1'b0;
                r_done[r_head]   <= 1'b0;
                r_head           <= r_head + 2'd1;
            end
            // Retirement is in order, so the tail entry is free whenever alloc is allowed.
            if (i_alloc) begin
                r_issued[r_tail] <= 1'b1;
                r_done[r_tail]   <= 1'b0;
`ifdef CALC2_ISSUE_TIMEOUT_EN
                r_cnt[r_tail]    <= '0;
`endif
                r_tail           <= r_tail + 2'd1;
            end
            r_outstanding <= r_outstanding + {2'b00, i_alloc} - {2'b00, i_retire};
        end
    end

    assign o_tail         = r_tail;
    assign o_head_done    = r_done[r_head];
    assign o_head_resp    = r_resp[r_head];
    assign o_head_data    = r_data[r_head];
    assign o_head_tag     = r_head;
    assign o_outstanding  = r_outstanding;
    assign o_err_spurious = r_err;

endmodule

// File: rtl/calc2_port_issuer.sv
// Issues whole calc2 operations as two-cycle requests and returns results in issue order.
// Build with CALC2_ISSUE_TIMEOUT_EN to retire unanswered tags after TIMEOUT cycles.
module calc2_port_issuer
    import calc2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input logic                 c_clk,
    input logic                 reset,
    calc2_port_issuer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND1 = 2'd1;
    localparam logic [1:0] ST_SEND2 = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_d;
    logic [3:0]  r_req_cmd;
    logic [3:0]  w_req_cmd_d;
    logic [31:0] r_req_data;
    logic [31:0] w_req_data_d;
    tag_t        r_req_tag;
    tag_t        w_req_tag_d;
    logic [31:0] r_op2;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_retire;
    tag_t        w_tail;
    logic        w_head_done;
    logic [1:0]  w_head_resp;
    logic [31:0] w_head_data;
    tag_t        w_head_tag;
    logic [2:0]  w_outstanding;
    logic        w_err_spurious;

    assign w_in_ready = (r_state != ST_SEND1) & (w_outstanding < 3'd4) & ~reset;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_retire   = w_head_done & bus.out_ready;

    // Accept is never possible in SEND1, so SEND1 always falls through to SEND2.
    always_comb begin
        w_state_d    = ST_IDLE;
        w_req_cmd_d  = '0;
        w_req_data_d = '0;
        w_req_tag_d  = '0;
        if (w_accept) begin
            w_state_d    = ST_SEND1;
            w_req_cmd_d  = bus.in_cmd;
            w_req_data_d = bus.in_op1;
            w_req_tag_d  = w_tail;
        end else if (r_state == ST_SEND1) begin
            w_state_d    = ST_SEND2;
            w_req_data_d = r_op2;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req_cmd  <= '0;
            r_req_data <= '0;
            r_req_tag  <= '0;
            r_op2      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_req_cmd  <= w_req_cmd_d;
            r_req_data <= w_req_data_d;
            r_req_tag  <= w_req_tag_d;
            if (w_accept) begin
                r_op2 <= bus.in_op2;
            end
        end
    end

    calc2_tag_table #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_tag_table (
        .c_clk          (c_clk),
        .reset          (reset),
        .i_alloc        (w_accept),
        .i_retire       (w_retire),
        .i_dut_resp     (bus.dut_resp_in),
        .i_dut_data     (bus.dut_data_in),
        .i_dut_tag      (bus.dut_tag_in),
        .o_tail         (w_tail),
        .o_head_done    (w_head_done),
        .o_head_resp    (w_head_resp),
        .o_head_data    (w_head_data),
        .o_head_tag     (w_head_tag),
        .o_outstanding  (w_outstanding),
        .o_err_spurious (w_err_spurious)
    );

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_head_done;
    assign bus.out_resp     = w_head_done ? w_head_resp : 2'd0;
    assign bus.out_data     = w_head_done ? w_head_data : 32'd0;
    assign bus.out_tag      = w_head_done ? w_head_tag : 2'd0;
    assign bus.req_cmd_out  = r_req_cmd;
    assign bus.req_data_out = r_req_data;
    assign bus.req_tag_out  = r_req_tag;
    assign bus.outstanding  = w_outstanding;
    assign bus.err_spurious = w_err_spurious;

endmodule
